// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a program image over an 8N1 UART line and writes it
// word-by-word into the program driver's memory, then raises drive when the image is complete.
// Ports: clk/rst (sync, active-high), rx (async serial in), mem_we/mem_addr/mem_wdata (write
//        port to program memory), drive (image loaded), busy (frame in progress),
//        frame_err (sticky framing error), words_loaded (words written in current frame).
// Frame format: first byte is the length N (0 or anything above the depth means full depth),
// followed by N data bytes. mem_we follows the byte's internal valid pulse by one cycle.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              drive,
    output logic              busy,
    output logic              frame_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  IDX_ONE   = 1;
    localparam logic [BIT_W-1:0]  IDX_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   WORDS_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_MAX   = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE}               ld_state_t;

    // Length byte decode: zero selects the full memory depth; oversize lengths are
    // clamped so the loader can never write past the top address.
    function automatic logic [ADDR_W:0] decode_len(input logic [DATA_W-1:0] b);
        if (b == '0 || int'(b) > DEPTH) begin
            decode_len = LEN_MAX;
        end else begin
            decode_len = (ADDR_W+1)'(b);
        end
    endfunction

    // ------------------------------------------------------------------
    // rx synchroniser (idles high so reset never looks like a start bit)
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Bit-level receiver
    // ------------------------------------------------------------------
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              stop_bad_q, stop_bad_d;   // bad stop bit seen, waiting for line high
    logic              byte_vld_q, byte_vld_d;
    logic              ferr_pulse_q, ferr_pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            stop_bad_q   <= 1'b0;
            byte_vld_q   <= 1'b0;
            ferr_pulse_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            stop_bad_q   <= stop_bad_d;
            byte_vld_q   <= byte_vld_d;
            ferr_pulse_q <= ferr_pulse_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q + CNT_ONE;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        stop_bad_d   = stop_bad_q;
        byte_vld_d   = 1'b0;
        ferr_pulse_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_bad_d = 1'b0;
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + IDX_ONE;
                    if (bit_idx_q == IDX_LAST) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (stop_bad_q) begin
                    // Hold here until the line idles, so a long break is one error.
                    cnt_d = cnt_q;
                    if (rx_s_q) begin
                        rx_state_d = RX_IDLE;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_vld_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        ferr_pulse_d = 1'b1;
                        stop_bad_d   = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte-level loader
    // ------------------------------------------------------------------
    ld_state_t         ld_state_q, ld_state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic [ADDR_W:0]   words_q, words_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q  <= L_LEN;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            words_q     <= '0;
        end else begin
            ld_state_q  <= ld_state_d;
            len_q       <= len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            words_q     <= words_d;
        end
    end

    always_comb begin
        ld_state_d  = ld_state_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        drive_d     = drive_q;
        busy_d      = busy_q;
        frame_err_d = frame_err_q | ferr_pulse_q;
        words_d     = words_q;
        unique case (ld_state_q)
            L_LEN: begin
                if (byte_vld_q) begin
                    len_d      = decode_len(shift_q);
                    drive_d    = 1'b0;
                    busy_d     = 1'b1;
                    words_d    = '0;
                    mem_addr_d = '0;
                    ld_state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (ferr_pulse_q) begin
                    // Abort: already written words stay in memory, driver stays stopped.
                    busy_d     = 1'b0;
                    ld_state_d = L_LEN;
                end else if (byte_vld_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = shift_q;
                end
                // Address and count advance on the cycle after the strobe; completion
                // is decided here so drive rises right after the final write.
                if (mem_we_q) begin
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                    words_d    = words_q + WORDS_ONE;
                    if (words_q + WORDS_ONE == len_q) begin
                        drive_d    = 1'b1;
                        busy_d     = 1'b0;
                        ld_state_d = L_DONE;
                    end
                end
            end
            L_DONE: begin
                ld_state_d = L_LEN;
            end
            default: ld_state_d = L_LEN;
        endcase
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign drive        = drive_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Host-facing front end of the FPGA demo; sits directly upstream of the program driver.
- Receives a program image over a UART line (8N1, LSB first) and writes it word-by-word into the driver's program memory.
- When the image is complete, raises `drive` so the driver starts streaming the program into the processor.
- Replaces the simulation-only `$readmemh` preload with a runtime load path.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 8, program memory address width; depth = 2**ADDR_W.
- DATA_W, 8, program word width; fixed at 8, one UART byte per word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART receive line, idle high.
- mem_we  out  1  one-cycle write strobe to driver program memory.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- drive  out  1  level; high = image loaded, driver may run.
- busy  out  1  high from length-byte acceptance until image complete or abort.
- frame_err  out  1  sticky framing-error flag.
- words_loaded  out  ADDR_W+1  count of words written in the current frame.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, drive=0, busy=0, frame_err=0, words_loaded=0. Both FSMs go to idle.
- rx input path:
  - Two-flop synchroniser; the synchroniser resets to 1.
  - All decisions use the synchronised rx (rx_s).
- Bit-level FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: rx_s==0 -> RX_START, bit counter cleared.
  - RX_START: wait CLKS_PER_BIT/2 cycles (integer divide). If rx_s==1 at the sample point, treat as a glitch and return to RX_IDLE with no error. Else -> RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles; 8 samples, LSB first, shifted into the byte register -> RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - rx_s==1: byte_valid pulses for 1 cycle.
    - rx_s==0: frame_err<=1, no byte_valid, and the FSM stays in RX_STOP until rx_s==1, then -> RX_IDLE.
- Byte-level FSM, states L_LEN, L_DATA, L_DONE:
  - L_LEN, on byte_valid:
    - Stores length N, where value 0 means 2**ADDR_W.
    - Sets drive<=0, busy<=1, words_loaded<=0, mem_addr<=0.
    - -> L_DATA.
  - L_DATA, on byte_valid:
    - Next cycle: mem_we=1, mem_wdata=byte, mem_addr=current address.
    - The cycle after the strobe: mem_addr increments and words_loaded increments.
    - When words_loaded reaches N -> L_DONE.
  - L_DONE: drive<=1 and busy<=0 in the same cycle; -> L_LEN, ready for a new frame.
- Write latency: mem_we is asserted exactly 1 cycle after the byte_valid that follows the stop-bit sample.
- Framing error while in L_DATA:
  - Aborts the frame: busy<=0, drive stays 0, -> L_LEN.
  - Words already written are not reverted.
  - frame_err stays 1 until rst.
- A framing error in L_LEN only sets frame_err.
- drive stays high until rst or until the next length byte is accepted; a reload therefore always stops the driver first.
- mem_addr wraps modulo 2**ADDR_W. With N = 2**ADDR_W the last write goes to the top address and no wrap write occurs.
- rst asserted mid-byte or mid-frame: on the next edge all outputs return to their reset values and the partial byte is discarded. Memory contents are untouched.
- Only one byte can be in flight at a time, so byte_valid and mem_we never collide.

Test Plan:
- Sim setup: CLKS_PER_BIT=4 for all scenarios.
- Frame 0x03,0xA1,0xB2,0xC3 -> exactly three mem_we pulses: (0,0xA1), (1,0xB2), (2,0xC3). drive rises 1 cycle after the third strobe; busy falls in the same cycle; words_loaded=3; frame_err=0.
- 1-cycle low glitch on an idle rx -> no byte accepted, frame_err=0, no mem_we.
- Frame 0x02,0x11, then a byte with stop bit=0 -> a single write (0,0x11); frame_err=1; drive=0; busy=0. A following valid frame 0x01,0x55 loads with drive=1 and frame_err still 1.
- With drive=1, send length 0x02 -> drive falls the cycle after that byte's byte_valid; writes restart at address 0.
- Length 0x00 with ADDR_W=4 -> 16 writes to addresses 0..15, then drive=1 and words_loaded=16.
- rst pulsed during the 5th data bit of the 2nd data byte -> next cycle every output is at its reset value. A fresh frame 0x01,0x7E then loads correctly: write (0,0x7E).
